// File: rtl/dmem_ctrl.sv
// Data-memory responder for miniRV lw/lbu/sw/sb over a word-organised synchronous-read RAM.
// Loads and sw complete in 2 cycles after acceptance and sb in 3; requests arriving while busy are dropped.
module dmem_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [1:0]  addr10,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  st_we;
  logic                  st_byte;
  logic [31:0]           st_wdata;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic                  wr_en;
  logic [31:0]           wr_word;

  // Out-of-range word indices alias onto the RAM; the upper bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2];

  function automatic logic [7:0] pick_lane(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    pick_lane = w[7:0];
      2'd1:    pick_lane = w[15:8];
      2'd2:    pick_lane = w[23:16];
      default: pick_lane = w[31:24];
    endcase
  endfunction

  always_comb begin
    merged = rd_word;
    case (lane)
      2'd0:    merged[7:0]   = st_wdata[7:0];
      2'd1:    merged[15:8]  = st_wdata[7:0];
      2'd2:    merged[23:16] = st_wdata[7:0];
      default: merged[31:24] = st_wdata[7:0];
    endcase
  end

  // Reset in WR/MERGE must cancel the pending write.
  assign wr_en   = !rst && (state == WR || state == MERGE);
  assign wr_word = (state == WR) ? st_wdata : merged;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_word;
    end
    if (state == RD) begin
      rd_word <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (state == RD && !st_we) begin
      rdata <= st_byte ? {24'd0, pick_lane(mem[idx], lane)} : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx      <= addr[DEPTH_LOG2-1:0];
            lane     <= addr10;
            st_we    <= we;
            st_byte  <= byte_en;
            st_wdata <= wdata;
            busy     <= 1'b1;
            state    <= (we && !byte_en) ? WR : RD;
          end
        end
        RD: begin
          // Byte stores read first so the other three lanes can be preserved.
          if (st_we) begin
            state <= MERGE;
          end else begin
            state <= RESP;
            done  <= 1'b1;
          end
        end
        MERGE, WR: begin
          state <= RESP;
          done  <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: reset, word/byte round-trips, aliasing, busy rejection, reset mid-store, back-to-back.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic        byte_en;
  logic [31:0] addr;
  logic [1:0]  addr10;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl #(.DEPTH_LOG2(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .byte_en (byte_en),
    .addr    (addr),
    .addr10  (addr10),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access from IDLE, return cycles from acceptance to done, then settle back in IDLE.
  task automatic access(input logic w, input logic b, input logic [31:0] a, input logic [1:0] o,
                        input logic [31:0] d, output int lat);
    we = w; byte_en = b; addr = a; addr10 = o; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    tick();
  endtask

  int lat;
  int ndone;
  logic [31:0] lbu_exp [4];

  initial begin
    lbu_exp[0] = 32'h44; lbu_exp[1] = 32'h33; lbu_exp[2] = 32'hAA; lbu_exp[3] = 32'h11;

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    req = 1'($urandom); we = 1'($urandom); byte_en = 1'($urandom);
    addr = $urandom; addr10 = 2'($urandom); wdata = $urandom;
    #1;
    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0; req = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("post_reset_no_done", ndone, 0);

    // Word round-trip and aliasing.
    access(1'b1, 1'b0, 32'd5, 2'd0, 32'hDEADBEEF, lat);
    chk("sw_latency", lat, 2);
    access(1'b0, 1'b0, 32'd5, 2'd0, 32'd0, lat);
    chk("lw_latency", lat, 2);
    chk("lw5_rdata", rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'd1029, 2'd0, 32'd0, lat);
    chk("lw_alias_rdata", rdata, 32'hDEADBEEF);

    // Byte merge.
    access(1'b1, 1'b0, 32'd7, 2'd0, 32'h11223344, lat);
    access(1'b1, 1'b1, 32'd7, 2'd2, 32'h000000AA, lat);
    chk("sb_latency", lat, 3);
    chk("sb_keeps_rdata", rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'd7, 2'd0, 32'd0, lat);
    chk("lw7_merged", rdata, 32'h11AA3344);
    for (int k = 0; k < 4; k++) begin
      access(1'b0, 1'b1, 32'd7, 2'(k), 32'd0, lat);
      chk($sformatf("lbu7_lane%0d", k), rdata, lbu_exp[k]);
    end

    // Store request while busy must be dropped.
    access(1'b1, 1'b0, 32'd3, 2'd0, 32'h12345678, lat);
    we = 1'b0; byte_en = 1'b0; addr = 32'd3; addr10 = 2'd0; req = 1'b1;
    tick();
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    we = 1'b1; wdata = 32'hFFFFFFFF;
    tick();
    req = 1'b0; we = 1'b0;
    ndone = done ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("busy_reject_one_done", ndone, 1);
    access(1'b0, 1'b0, 32'd3, 2'd0, 32'd0, lat);
    chk("busy_reject_word3", rdata, 32'h12345678);

    // Reset during WR.
    access(1'b1, 1'b0, 32'd9, 2'd0, 32'h0, lat);
    we = 1'b1; byte_en = 1'b0; addr = 32'd9; wdata = 32'hFFFFFFFF; req = 1'b1;
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wr_busy", {31'd0, busy}, 32'd0);
    ndone = done ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("rst_wr_no_done", ndone, 0);
    access(1'b0, 1'b0, 32'd9, 2'd0, 32'd0, lat);
    chk("rst_wr_word9", rdata, 32'h0);

    // Reset during MERGE.
    we = 1'b1; byte_en = 1'b1; addr = 32'd9; addr10 = 2'd1; wdata = 32'hFFFFFFFF; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ndone = done ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("rst_merge_no_done", ndone, 0);
    access(1'b0, 1'b0, 32'd9, 2'd0, 32'd0, lat);
    chk("rst_merge_word9", rdata, 32'h0);

    // Back-to-back with req held high: lw 5, lw 7, sb 7 lane0.
    we = 1'b0; byte_en = 1'b0; addr = 32'd5; addr10 = 2'd0; req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("b2b_done_cycle%0d", k + 1), {31'd0, done},
          {31'd0, (k == 1 || k == 4 || k == 8)});
      if (k == 0) begin
        addr = 32'd7;
      end
      if (k == 3) begin
        we = 1'b1; byte_en = 1'b1; addr = 32'd7; addr10 = 2'd0; wdata = 32'h00000055;
      end
      if (k == 6) req = 1'b0;
      if (k == 1) chk("b2b_lw5", rdata, 32'hDEADBEEF);
      if (k == 4) chk("b2b_lw7", rdata, 32'h11AA3344);
      if (k == 8) chk("b2b_sb_keeps_rdata", rdata, 32'h11AA3344);
    end
    we = 1'b0; byte_en = 1'b0;
    access(1'b0, 1'b0, 32'd7, 2'd0, 32'd0, lat);
    chk("b2b_sb_result", rdata, 32'h11AA3355);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for miniRV load/store instructions: consumes the word index and byte offset produced by the ALU address path, and executes `lw`, `lbu`, `sw` and `sb` against an internal word-organised, synchronous-read RAM. A small FSM sequences each access, including read-modify-write for byte stores. Completion is signalled with a one-cycle `done` pulse. It sits between the datapath's ALU/register file and the writeback mux, as the memory end of the address/data interface.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of RAM depth in 32-bit words (default 1024 words).

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  1  access request; sampled only when `busy`=0.
- `we`  input  1  1 = store, 0 = load.
- `byte_en`  input  1  1 = byte access (`lbu`/`sb`), 0 = word access (`lw`/`sw`).
- `addr`  input  32  word index (effective address >> 2).
- `addr10`  input  2  byte offset (effective address [1:0]).
- `wdata`  input  32  store data; `sb` uses `wdata[7:0]` only.
- `busy`  output  1  high while an access is in flight (state != IDLE).
- `done`  output  1  one-cycle pulse when an access completes.
- `rdata`  output  32  load result; valid from the `done` cycle and held until the next load completes.

## Operation
- **Reset.** Synchronous and active-high; it has priority over everything else.
  - State = IDLE; `busy`=0, `done`=0, `rdata`=0.
  - RAM contents are not initialised.
- **Request capture.** In IDLE with `req`=1, latch `addr[DEPTH_LOG2-1:0]`, `addr10`, `we`, `byte_en` and `wdata`.
  - Upper `addr` bits are ignored, so out-of-range indices alias (wrap modulo depth).
  - `req` while `busy`=1 is ignored; there is no queue.
- **States.** IDLE, RD, MERGE, WR, RESP.
  - `lw`: IDLE -> RD -> RESP -> IDLE.
    - RD issues the RAM read.
    - RESP drives `rdata` = RAM word and `done`=1.
  - `lbu`: same path as `lw`.
    - `rdata` = {24'b0, selected byte}.
    - Lanes are little-endian: `addr10`=0 -> bits 7:0, 1 -> 15:8, 2 -> 23:16, 3 -> 31:24.
  - `sw`: IDLE -> WR -> RESP -> IDLE.
    - The full word is written on the edge leaving WR.
    - `addr10` is ignored; misaligned words do not trap.
  - `sb`: IDLE -> RD -> MERGE -> RESP -> IDLE.
    - MERGE replaces the lane selected by `addr10` with `wdata[7:0]`, preserves the other three lanes, and writes the merged word on the edge leaving MERGE.
- **Output behaviour.**
  - Stores never modify `rdata`.
  - `done` is high only in RESP.
  - `busy` stays high in RESP, so a new `req` is accepted only once IDLE is re-entered.
- **Reset mid-operation.** If `rst`=1 while in WR or MERGE, the RAM write is suppressed. The FSM returns to IDLE with no `done` pulse.

## Timing
- Cycle N is the cycle in which `req`=1 is sampled in IDLE.
- Latency from acceptance to `done`:
  - `lw`/`lbu`: state RD at N+1, `done` at N+2.
  - `sw`: state WR at N+1, `done` at N+2; the write is visible to a read issued at N+3 or later.
  - `sb`: `done` at N+3.
- Maximum throughput: one access per 3 cycles (`lw`/`lbu`/`sw`), one per 4 cycles (`sb`). A `req` held high through RESP is accepted in the first IDLE cycle.
- `busy` rises at N+1 and falls in the cycle after RESP.
- `rdata` updates on the edge entering RESP and is stable until the next load's RESP.
- RAM has a single port with a 1-cycle synchronous read, so at most one read or write occurs per cycle.

## Test plan
- **Reset.** Hold `rst` for 2 cycles with random inputs -> `busy`=0, `done`=0, `rdata`=0; no `done` for 5 cycles after release.
- **Word round-trip.**
  - `sw` `addr`=5, `wdata`=0xDEADBEEF -> `done` at N+2.
  - Then `lw` `addr`=5 -> `rdata`=0xDEADBEEF at `done`.
  - Then `lw` `addr`=5+2^DEPTH_LOG2 -> same value (aliasing).
- **Byte merge.**
  - Preload word 7 = 0x11223344.
  - `sb` `addr`=7, `addr10`=2, `wdata`=0x000000AA -> `done` at N+3.
  - `lw` 7 -> 0x11AA3344.
  - `lbu` 7 with `addr10`=0..3 -> 0x44, 0x33, 0xAA, 0x11.
- **Busy rejection.**
  - `lw` to word 3; while `busy`, pulse `req` with `we`=1 to word 3 -> that store never executes.
  - Word 3 unchanged; exactly one `done`.
- **Reset mid-store.**
  - Word 9 = 0x0; start `sw` 0xFFFFFFFF to word 9; assert `rst` in the WR cycle -> no `done`.
  - A subsequent `lw` 9 -> 0x0.
  - Repeat with `sb` and `rst` in MERGE -> same result.
- **Back-to-back.** Hold `req` high across `lw`, `lw`, `sb` -> accepted at cycles 0, 3, 6; `done` at 2, 5, 9; `rdata` unchanged after the `sb`.
